seven_seg_scan_mux: RTL and testbench

//  Parametrised time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.

---
 rtl/seven_seg_pkg.sv | 29 ++
 rtl/seven_seg_scan_mux_if.sv | 22 ++
 rtl/hex_to_seg.sv | 33 +++
 rtl/seven_seg_scan_mux.sv | 168 ++++++++++++++++
 tb/tb_seven_seg_scan_mux.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and segment constants for the multiplexed 7-segment driver.
// Segment patterns are active-high, bit order gfedcba.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/seven_seg_scan_mux_if.sv
// Display bundle: user-side digit values/enables in, pin-side segment/select drive out.
interface seven_seg_scan_mux_if #(
  parameter int N_DIGITS = 2
);
  logic [4*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   digit_en;
  logic [N_DIGITS-1:0]   dp_in;
  logic [6:0]            seg_out;
  logic                  dp_out;
  logic [N_DIGITS-1:0]   digit_sel;
  logic                  frame_start;

  modport master (
    output digits_in, digit_en, dp_in,
    input  seg_out, dp_out, digit_sel, frame_start
  );

  modport slave (
    input  digits_in, digit_en, dp_in,
    output seg_out, dp_out, digit_sel, frame_start
  );
endinterface

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high gfedcba segment pattern.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup over the package constants
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed N-digit 7-segment scanner with per-frame input snapshot,
// blanking gap between slots and registered, polarity-adjusted outputs.
module seven_seg_scan_mux
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS        = 2,
  parameter int TICKS_PER_DIGIT = 24000,
  parameter int BLANK_TICKS     = 240,
  parameter int SEG_ACTIVE_LOW  = 1,
  parameter int SEL_ACTIVE_LOW  = 1
) (
  input logic                clk,
  input logic                reset,
  seven_seg_scan_mux_if.slave disp
);

  localparam int MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam int IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);
  localparam scan_state_t      GAP_STATE  = (BLANK_TICKS == 0) ? SHOW : BLANK;
  localparam logic             SEG_POL    = 1'(SEG_ACTIVE_LOW != 0);
  localparam logic             SEL_POL    = 1'(SEL_ACTIVE_LOW != 0);

  if (N_DIGITS < 1) begin : g_bad_digits
    $error("seven_seg_scan_mux: N_DIGITS must be >= 1");
  end
  if (TICKS_PER_DIGIT < 1) begin : g_bad_ticks
    $error("seven_seg_scan_mux: TICKS_PER_DIGIT must be >= 1");
  end

  scan_state_t           state_r, state_n;
  logic [IDX_W-1:0]      idx_r, idx_n;
  logic [CNT_W-1:0]      cnt_r, cnt_n;
  logic [4*N_DIGITS-1:0] dig_r, dig_nx_s;
  logic [N_DIGITS-1:0]   en_r, en_nx_s;
  logic [N_DIGITS-1:0]   dp_r, dp_nx_s;
  logic                  load_s;

  logic [3:0]            nib_s;
  logic                  en_s;
  logic                  dpv_s;
  logic [N_DIGITS-1:0]   sel_hit_s;
  logic                  lit_s;
  logic [6:0]            seg_hex_s;
  logic [6:0]            seg_act_s;
  logic [N_DIGITS-1:0]   sel_act_s;

  logic [6:0]            seg_r;
  logic                  dpo_r;
  logic [N_DIGITS-1:0]   sel_r;
  logic                  fs_r;

  assign load_s = (state_r == LOAD);

  // Scan sequencing: next state, slot index and tick counter
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    cnt_n   = cnt_r;
    case (state_r)
      LOAD: begin
        cnt_n   = '0;
        state_n = GAP_STATE;
      end
      BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          cnt_n   = '0;
          state_n = SHOW;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      SHOW: begin
        if (cnt_r == SHOW_LAST) begin
          cnt_n = '0;
          if (idx_r == LAST_IDX) begin
            idx_n   = '0;
            state_n = LOAD;
          end else begin
            idx_n   = idx_r + IDX_W'(1);
            state_n = GAP_STATE;
          end
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        idx_n   = '0;
        cnt_n   = '0;
        state_n = LOAD;
      end
    endcase
  end

  // Shadow values as they will be after this edge, so the slot after LOAD sees the new frame
  always_comb begin
    dig_nx_s = load_s ? disp.digits_in : dig_r;
    en_nx_s  = load_s ? disp.digit_en  : en_r;
    dp_nx_s  = load_s ? disp.dp_in     : dp_r;
  end

  // Select the shadow entry for the upcoming slot
  always_comb begin
    nib_s     = 4'h0;
    en_s      = 1'b0;
    dpv_s     = 1'b0;
    sel_hit_s = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_n == IDX_W'(i)) begin
        sel_hit_s[i] = 1'b1;
        nib_s        = dig_nx_s[4*i +: 4];
        en_s         = en_nx_s[i];
        dpv_s        = dp_nx_s[i];
      end else begin
        sel_hit_s[i] = 1'b0;
      end
    end
  end

  hex_to_seg u_dec (
    .nibble (nib_s),
    .seg    (seg_hex_s)
  );

  // Active-high drive values for the next cycle; dark outside a lit SHOW slot
  always_comb begin
    lit_s     = (state_n == SHOW) && en_s;
    seg_act_s = lit_s ? seg_hex_s : SEG_OFF;
    sel_act_s = lit_s ? sel_hit_s : '0;
  end

  // State, shadow and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LOAD;
      idx_r   <= '0;
      cnt_r   <= '0;
      dig_r   <= '0;
      en_r    <= '0;
      dp_r    <= '0;
      seg_r   <= {7{SEG_POL}};
      dpo_r   <= SEG_POL;
      sel_r   <= {N_DIGITS{SEL_POL}};
      fs_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      cnt_r   <= cnt_n;
      dig_r   <= dig_nx_s;
      en_r    <= en_nx_s;
      dp_r    <= dp_nx_s;
      seg_r   <= seg_act_s ^ {7{SEG_POL}};
      dpo_r   <= (lit_s && dpv_s) ^ SEG_POL;
      sel_r   <= sel_act_s ^ {N_DIGITS{SEL_POL}};
      fs_r    <= load_s;
    end
  end

  assign disp.seg_out     = seg_r;
  assign disp.dp_out      = dpo_r;
  assign disp.digit_sel   = sel_r;
  assign disp.frame_start = fs_r;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Scoreboard bench: a frame-position reference model pushes expected outputs per cycle,
// a monitor pops and compares them on the falling edge. Two instances cover both polarities.
module tb_seven_seg_scan_mux;

  localparam int NA = 4, TA = 8, BA = 2, FA = 1 + NA * (BA + TA);
  localparam int NB = 1, TB = 1, BB = 0, FB = 1 + NB * (BB + TB);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_mux_if #(.N_DIGITS(NA)) if_a ();
  seven_seg_scan_mux_if #(.N_DIGITS(NB)) if_b ();

  seven_seg_scan_mux #(
    .N_DIGITS(NA), .TICKS_PER_DIGIT(TA), .BLANK_TICKS(BA),
    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut_a (.clk(clk), .reset(reset), .disp(if_a));

  seven_seg_scan_mux #(
    .N_DIGITS(NB), .TICKS_PER_DIGIT(TB), .BLANK_TICKS(BB),
    .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)
  ) dut_b (.clk(clk), .reset(reset), .disp(if_b));

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Expected {frame_start, dp, seg, sel} for frame position p, independent of any FSM
  function automatic logic [31:0] model_out(input int n, input int t, input int b, input bit act_low,
                                            input int p, input logic [15:0] dig,
                                            input logic [3:0] en, input logic [3:0] dp);
    logic [3:0] sel = 4'h0;
    logic [6:0] seg = 7'h00;
    logic       d   = 1'b0;
    logic       fs  = (p == 1);
    logic [3:0] mask = 4'((1 << n) - 1);
    if (p != 0) begin
      int q = p - 1;
      int slot = q / (b + t);
      int r = q % (b + t);
      if (r >= b && en[slot]) begin
        sel[slot] = 1'b1;
        seg = tbl[dig[4*slot +: 4]];
        d = dp[slot];
      end
    end
    if (act_low) begin
      seg = ~seg;
      d   = ~d;
      sel = ~sel & mask;
    end
    return (32'(fs) << (n + 8)) | (32'(d) << (n + 7)) | (32'(seg) << n) | 32'(sel);
  endfunction

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  int ka = 0, kb = 0;
  logic [15:0] snap_dig_a, snap_dig_b;
  logic [3:0]  snap_en_a, snap_en_b, snap_dp_a, snap_dp_b;

  // Reference model: snapshot at frame position 0, push expectation for the current cycle
  always @(posedge clk) begin
    logic rs;
    int pa, pb;
    rs = reset;
    #2;
    if (rs) begin
      ka = 0;
      kb = 0;
    end
    pa = ka % FA;
    pb = kb % FB;
    if (pa == 0) begin
      snap_dig_a = 16'(if_a.digits_in);
      snap_en_a  = 4'(if_a.digit_en);
      snap_dp_a  = 4'(if_a.dp_in);
    end
    if (pb == 0) begin
      snap_dig_b = 16'(if_b.digits_in);
      snap_en_b  = 4'(if_b.digit_en);
      snap_dp_b  = 4'(if_b.dp_in);
    end
    q_a.push_back(model_out(NA, TA, BA, 1'b1, pa, snap_dig_a, snap_en_a, snap_dp_a));
    q_b.push_back(model_out(NB, TB, BB, 1'b0, pb, snap_dig_b, snap_en_b, snap_dp_b));
    ka++;
    kb++;
  end

  int ncyc = 0;
  int last_a = -1, last_b = -1;

  // Monitor: compare DUT outputs against the scoreboard and measure frame_start spacing
  always @(negedge clk) begin
    logic [31:0] exp_v;
    ncyc++;
    check_val("sb_a_depth", 32'(q_a.size()), 32'd1);
    check_val("sb_b_depth", 32'(q_b.size()), 32'd1);
    if (q_a.size() > 0) begin
      exp_v = q_a.pop_front();
      check_val("out_a", 32'({if_a.frame_start, if_a.dp_out, if_a.seg_out, if_a.digit_sel}), exp_v);
    end
    if (q_b.size() > 0) begin
      exp_v = q_b.pop_front();
      check_val("out_b", 32'({if_b.frame_start, if_b.dp_out, if_b.seg_out, if_b.digit_sel}), exp_v);
    end
    if (reset) begin
      last_a = -1;
      last_b = -1;
    end else begin
      if (if_a.frame_start === 1'b1) begin
        if (last_a >= 0) check_val("fs_period_a", 32'(ncyc - last_a), 32'(FA));
        last_a = ncyc;
      end
      if (if_b.frame_start === 1'b1) begin
        if (last_b >= 0) check_val("fs_period_b", 32'(ncyc - last_b), 32'(FB));
        last_b = ncyc;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Instance B: walk every hex value for one frame each, then random values
  initial begin
    if_b.digits_in = 4'h0;
    if_b.digit_en  = 1'b1;
    if_b.dp_in     = 1'b0;
    cycles(4);
    for (int v = 0; v < 16; v++) begin
      if_b.digits_in = 4'(v);
      if_b.dp_in     = 1'(v);
      cycles(2);
    end
    forever begin
      if_b.digits_in = 4'($urandom_range(15, 0));
      if_b.digit_en  = 1'($urandom_range(3, 0) != 0);
      if_b.dp_in     = 1'($urandom_range(1, 0));
      cycles(1);
    end
  end

  // Instance A scenarios plus shared reset sequencing
  initial begin
    if_a.digits_in = 16'h3210;
    if_a.digit_en  = 4'hF;
    if_a.dp_in     = 4'h0;
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(7);
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(90);
    cycles(15);
    if_a.digits_in = 16'h9999;
    cycles(90);
    if_a.digits_in = 16'h3210;
    if_a.digit_en  = 4'b0101;
    if_a.dp_in     = 4'b0001;
    cycles(90);
    for (int i = 0; i < 400; i++) begin
      if_a.digits_in = 16'($urandom);
      if_a.digit_en  = 4'($urandom_range(15, 0));
      if_a.dp_in     = 4'($urandom_range(15, 0));
      reset          = ($urandom_range(59, 0) == 0);
      cycles(1);
    end
    reset = 1'b0;
    cycles(100);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
